// File: rtl/memory_pipe_pkg.sv
// Shared types and helpers for memory_pipe.
// Holds the sequencer state enum, the read-latency ceiling and a per-byte
// even-parity helper used by the parity option (MEMORY_PARITY_EN).
package memory_pipe_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned RD_LATENCY_MAX = 4;

    // Parity helper works on a fixed maximum word; callers cast in and out.
    localparam int unsigned PAR_MAX_BYTES = 64;
    localparam int unsigned PAR_MAX_BITS  = PAR_MAX_BYTES * 8;

    // Even parity per byte: bit i is the XOR of byte i.
    function automatic logic [PAR_MAX_BYTES-1:0] byte_parity(input logic [PAR_MAX_BITS-1:0] data);
        logic [PAR_MAX_BYTES-1:0] par;
        par = '0;
        for (int unsigned i = 0; i < PAR_MAX_BYTES; i++) begin
            par[i] = ^data[i*8 +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/memory_pipe_if.sv
// Request/response bus of memory_pipe.
// master: drives memory_en/wr/addr/be/data_in/clr (and memory_par_inj),
//         receives memory_ready/vld_out/data_out/err (and memory_par_err).
// slave : the memory side of the same signals.
// Parity signals exist only when MEMORY_PARITY_EN is defined.
interface memory_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  memory_en;
    logic                  memory_wr;
    logic [ADDR_WIDTH-1:0] memory_addr;
    logic [BE_WIDTH-1:0]   memory_be;
    logic [DATA_WIDTH-1:0] memory_data_in;
    logic                  memory_clr;
    logic                  memory_ready;
    logic                  memory_vld_out;
    logic [DATA_WIDTH-1:0] memory_data_out;
    logic                  memory_err;
`ifdef MEMORY_PARITY_EN
    logic                  memory_par_inj;
    logic                  memory_par_err;
`endif

    modport master (
`ifdef MEMORY_PARITY_EN
        output memory_par_inj,
        input  memory_par_err,
`endif
        output memory_en,
        output memory_wr,
        output memory_addr,
        output memory_be,
        output memory_data_in,
        output memory_clr,
        input  memory_ready,
        input  memory_vld_out,
        input  memory_data_out,
        input  memory_err
    );

    modport slave (
`ifdef MEMORY_PARITY_EN
        input  memory_par_inj,
        output memory_par_err,
`endif
        input  memory_en,
        input  memory_wr,
        input  memory_addr,
        input  memory_be,
        input  memory_data_in,
        input  memory_clr,
        output memory_ready,
        output memory_vld_out,
        output memory_data_out,
        output memory_err
    );

endinterface

// File: rtl/memory_pipe_rdpipe.sv
// Read-response shift register of memory_pipe: RD_LATENCY stages carrying
// valid, data, err (and par_err with MEMORY_PARITY_EN).
// Ports: clk, rst_n (async active low), in_* from the accept stage,
//        out_* registered response. out_data holds the last valid word;
//        out_err/out_par_err are forced low whenever out_vld is low.
module memory_pipe_rdpipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_err,
`ifdef MEMORY_PARITY_EN
    input  logic                  in_par_err,
    output logic                  out_par_err,
`endif
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] err_q, err_d;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_d [RD_LATENCY];
`ifdef MEMORY_PARITY_EN
    logic [RD_LATENCY-1:0] perr_q, perr_d;
`endif

    // Shift every cycle; data only advances with a valid so the tail holds.
    always_comb begin
        vld_d  = '0;
        err_d  = '0;
        data_d = data_q;
        vld_d[0]  = in_vld;
        err_d[0]  = in_vld & in_err;
        data_d[0] = in_vld ? in_data : data_q[0];
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

`ifdef MEMORY_PARITY_EN
    always_comb begin
        perr_d    = '0;
        perr_d[0] = in_vld & in_par_err;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            perr_d[i] = perr_q[i-1];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
`ifdef MEMORY_PARITY_EN
            perr_q <= '0;
`endif
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            data_q <= data_d;
`ifdef MEMORY_PARITY_EN
            perr_q <= perr_d;
`endif
        end
    end

    assign out_vld  = vld_q[RD_LATENCY-1];
    assign out_err  = err_q[RD_LATENCY-1];
    assign out_data = data_q[RD_LATENCY-1];
`ifdef MEMORY_PARITY_EN
    assign out_par_err = perr_q[RD_LATENCY-1];
`endif

endmodule

// File: rtl/memory_pipe.sv
// Single-port scratch memory with byte-enable writes, RD_LATENCY read
// pipeline, hardware clear sequencer and out-of-range detection.
// Ports: memory_clk (rising edge), memory_rst (async, active low),
//        bus (memory_pipe_if.slave) carrying requests and read responses.
// Option: MEMORY_PARITY_EN adds per-byte even parity storage, write-side
//         parity injection (memory_par_inj) and read-side memory_par_err.
module memory_pipe
    import memory_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic         memory_clk,
    input  logic         memory_rst,
    memory_pipe_if.slave bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef MEMORY_PARITY_EN
    logic [BE_WIDTH-1:0]   par_q [DEPTH];
    logic [BE_WIDTH-1:0]   wpar_c;
    logic                  rd_par_err_c;
`endif

    logic                  accept_c;
    logic                  in_range_c;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic                  we_c;
    logic [ADDR_WIDTH-1:0] waddr_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [BE_WIDTH-1:0]   wmask_c;
    logic                  rd_vld_c;
    logic                  rd_err_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    // A clear pulse in READY wins over any request in the same cycle.
    assign accept_c   = bus.memory_en & ready_q & ~bus.memory_clr;
    assign in_range_c = (32'(bus.memory_addr) < DEPTH);
    assign idx_c      = in_range_c ? bus.memory_addr : '0;

    // Clear sequencer: CLEAR walks the counter once over the array.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (bus.memory_clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == READY);
    end

    always_ff @(posedge memory_clk or negedge memory_rst) begin
        if (!memory_rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Single write port shared by the clear walk and accepted in-range writes.
    always_comb begin
        we_c    = 1'b0;
        waddr_c = cnt_q;
        wdata_c = '0;
        wmask_c = '0;
        if (state_q == CLEAR) begin
            we_c    = 1'b1;
            wmask_c = '1;
        end else if (accept_c && bus.memory_wr && in_range_c) begin
            we_c    = 1'b1;
            waddr_c = bus.memory_addr;
            wdata_c = bus.memory_data_in;
            wmask_c = bus.memory_be;
        end
    end

`ifdef MEMORY_PARITY_EN
    // Injection flips parity of the bytes being written; CLEAR stores zero.
    always_comb begin
        wpar_c = '0;
        if (state_q != CLEAR) begin
            wpar_c = BE_WIDTH'(byte_parity(PAR_MAX_BITS'(bus.memory_data_in)))
                   ^ (bus.memory_par_inj ? bus.memory_be : BE_WIDTH'(0));
        end
    end
`endif

    // Storage array; contents are defined by the clear walk, not by reset.
    always_ff @(posedge memory_clk) begin
        if (we_c) begin
            for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                if (wmask_c[b]) begin
                    mem_q[waddr_c][b*8 +: 8] <= wdata_c[b*8 +: 8];
`ifdef MEMORY_PARITY_EN
                    par_q[waddr_c][b] <= wpar_c[b];
`endif
                end
            end
        end
    end

    // Read sample at the accept edge; out-of-range reads return zero + err.
    assign rd_vld_c  = accept_c & ~bus.memory_wr;
    assign rd_err_c  = ~in_range_c;
    assign rd_data_c = in_range_c ? mem_q[idx_c] : '0;
`ifdef MEMORY_PARITY_EN
    assign rd_par_err_c = in_range_c
        & (|(par_q[idx_c] ^ BE_WIDTH'(byte_parity(PAR_MAX_BITS'(mem_q[idx_c])))));
`endif

    memory_pipe_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe (
        .clk         (memory_clk),
        .rst_n       (memory_rst),
        .in_vld      (rd_vld_c),
        .in_data     (rd_data_c),
        .in_err      (rd_err_c),
`ifdef MEMORY_PARITY_EN
        .in_par_err  (rd_par_err_c),
        .out_par_err (bus.memory_par_err),
`endif
        .out_vld     (bus.memory_vld_out),
        .out_data    (bus.memory_data_out),
        .out_err     (bus.memory_err)
    );

    assign bus.memory_ready = ready_q;

endmodule
